// File: rtl/lpc_frame_packer.sv
// Serializes one LPC transaction record into a fixed-length UART byte frame.
// Define LPC_PACKER_HEX_EN for a 13-byte ASCII hex frame instead of the 7-byte binary one.
module lpc_frame_packer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        ext_clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cycle,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        frame_done
);

`ifdef LPC_PACKER_HEX_EN
  localparam logic [3:0] LAST = 4'd12;
`else
  localparam logic [3:0] LAST = 4'd6;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cyc_q, cyc_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;

`ifdef LPC_PACKER_HEX_EN
  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
`endif

  always_ff @(posedge ext_clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Held low during reset so upstream never sees a handshake that gets discarded.
        in_ready = !reset;
        if (in_valid && in_ready) begin
          cyc_d   = in_cycle;
          addr_d  = in_addr;
          data_d  = in_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
`ifdef LPC_PACKER_HEX_EN
      case (idx_q)
        4'd0:    tx_data = nib2asc(cyc_q);
        4'd1:    tx_data = nib2asc(addr_q[31:28]);
        4'd2:    tx_data = nib2asc(addr_q[27:24]);
        4'd3:    tx_data = nib2asc(addr_q[23:20]);
        4'd4:    tx_data = nib2asc(addr_q[19:16]);
        4'd5:    tx_data = nib2asc(addr_q[15:12]);
        4'd6:    tx_data = nib2asc(addr_q[11:8]);
        4'd7:    tx_data = nib2asc(addr_q[7:4]);
        4'd8:    tx_data = nib2asc(addr_q[3:0]);
        4'd9:    tx_data = nib2asc(data_q[7:4]);
        4'd10:   tx_data = nib2asc(data_q[3:0]);
        4'd11:   tx_data = 8'h0D;
        4'd12:   tx_data = 8'h0A;
        default: tx_data = 8'h00;
      endcase
`else
      case (idx_q)
        4'd0:    tx_data = SYNC_BYTE;
        4'd1:    tx_data = {4'h0, cyc_q};
        4'd2:    tx_data = addr_q[31:24];
        4'd3:    tx_data = addr_q[23:16];
        4'd4:    tx_data = addr_q[15:8];
        4'd5:    tx_data = addr_q[7:0];
        4'd6:    tx_data = data_q;
        default: tx_data = 8'h00;
      endcase
`endif
    end
  end

  assign frame_done = done_q;

endmodule
